// File: rtl/clock_mode_ctrl.sv
// Digital-clock front-panel control core.
// Holds the BCD time and alarm registers, sequences the display/edit mode
// from the debounced panel buttons, raises the alarm and drops back to run
// mode after an edit-idle timeout.
//
// state      | meaning
// -----------+--------------------------------------------------
// M_RUN      | run: time counts, btn_inc acknowledges the alarm
// M_SET_HR   | edit time hour   (time frozen)
// M_SET_MIN  | edit time minute (time frozen)
// M_SET_SEC  | edit time second (time frozen)
// M_AL_HR    | edit alarm hour   (time keeps running)
// M_AL_MIN   | edit alarm minute (time keeps running)
// M_AL_SEC   | edit alarm second (time keeps running)
module clock_mode_ctrl #(
   parameter int TIMEOUT_TICKS = 30,
   parameter int RING_TICKS    = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_12h,
   input  logic       alarm_en,
   output logic [2:0] mode,
   output logic       twelve,
   output logic [3:0] sec0,
   output logic [3:0] sec1,
   output logic [3:0] min0,
   output logic [3:0] min1,
   output logic [3:0] hour0,
   output logic [3:0] hour1,
   output logic [3:0] asec0,
   output logic [3:0] asec1,
   output logic [3:0] amin0,
   output logic [3:0] amin1,
   output logic [3:0] ahour0,
   output logic [3:0] ahour1,
   output logic       alarm_ring
);

   typedef enum logic [2:0] {
      M_RUN     = 3'd0,
      M_SET_HR  = 3'd1,
      M_SET_MIN = 3'd2,
      M_SET_SEC = 3'd3,
      M_AL_HR   = 3'd4,
      M_AL_MIN  = 3'd5,
      M_AL_SEC  = 3'd6
   } mode_t;

   // Idle counter only needs to reach TIMEOUT_TICKS; a zero timeout disables it.
   localparam int                IDLE_W  = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS + 1) : 1;
   localparam logic [IDLE_W-1:0] IDLE_TC = IDLE_W'(TIMEOUT_TICKS);
   localparam logic [IDLE_W-1:0] IDLE_1  = IDLE_W'(1);
   localparam bit                TO_EN   = (TIMEOUT_TICKS != 0);
   localparam logic [5:0]        RING_TC = 6'(RING_TICKS);

   mode_t             mode_q, mode_d;
   logic [IDLE_W-1:0] idle_q, idle_d;

   // Time and alarm kept as {tens, units} BCD pairs, always in 24 h form.
   logic [7:0] t_sec_q, t_min_q, t_hr_q;
   logic [7:0] t_sec_d, t_min_d, t_hr_d;
   logic [7:0] a_sec_q, a_min_q, a_hr_q;
   logic [7:0] a_sec_d, a_min_d, a_hr_d;

   logic       twelve_q;
   logic       ring_q, ring_d;
   logic [5:0] rcnt_q, rcnt_d;
   logic       upd_q;

   logic       inc_act;
   logic       time_runs;
   logic       time_upd;
   logic       time_eq;
   logic       ring_tc;
   logic       ring_clr;
   logic       ring_set;

   logic [8:0] sec_nx, min_nx, hr_nx;
   logic [8:0] asec_nx, amin_nx, ahr_nx;

   // {carry, tens, units} of a 00-59 BCD field plus one.
   function automatic logic [8:0] bcd_inc60(input logic [7:0] v);
      logic [8:0] r;
      if (v[3:0] >= 4'd9) begin
         if (v[7:4] >= 4'd5) r = 9'h100;
         else                r = {1'b0, v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {1'b0, v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   // {carry, tens, units} of a 00-23 BCD field plus one.
   function automatic logic [8:0] bcd_inc24(input logic [7:0] v);
      logic [8:0] r;
      if (v[7:4] >= 4'd2 && v[3:0] >= 4'd3) r = 9'h100;
      else if (v[3:0] >= 4'd9)             r = {1'b0, v[7:4] + 4'd1, 4'd0};
      else                                 r = {1'b0, v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   function automatic mode_t mode_after(input mode_t m);
      mode_t r;
      case (m)
         M_RUN:     r = M_SET_HR;
         M_SET_HR:  r = M_SET_MIN;
         M_SET_MIN: r = M_SET_SEC;
         M_SET_SEC: r = M_AL_HR;
         M_AL_HR:   r = M_AL_MIN;
         M_AL_MIN:  r = M_AL_SEC;
         default:   r = M_RUN;
      endcase
      return r;
   endfunction

   // btn_mode takes precedence, so a simultaneous btn_inc is dropped.
   assign inc_act   = btn_inc & ~btn_mode;
   assign time_runs = (mode_q == M_RUN) || (mode_q inside {M_AL_HR, M_AL_MIN, M_AL_SEC});
   assign time_upd  = tick_1hz & time_runs;

   assign sec_nx  = bcd_inc60(t_sec_q);
   assign min_nx  = bcd_inc60(t_min_q);
   assign hr_nx   = bcd_inc24(t_hr_q);
   assign asec_nx = bcd_inc60(a_sec_q);
   assign amin_nx = bcd_inc60(a_min_q);
   assign ahr_nx  = bcd_inc24(a_hr_q);

   // Mode state register and idle counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= M_RUN;
         idle_q <= '0;
      end else begin
         mode_q <= mode_d;
         idle_q <= idle_d;
      end
   end

   // Next mode: button advance, otherwise idle timeout back to run.
   always_comb begin
      mode_d = mode_q;
      idle_d = idle_q;
      if (mode_q == M_RUN) begin
         idle_d = '0;
         if (btn_mode) mode_d = M_SET_HR;
      end else if (btn_mode || btn_inc) begin
         idle_d = '0;
         if (btn_mode) mode_d = mode_after(mode_q);
      end else if (tick_1hz && TO_EN) begin
         if (idle_q + IDLE_1 == IDLE_TC) begin
            mode_d = M_RUN;
            idle_d = '0;
         end else begin
            idle_d = idle_q + IDLE_1;
         end
      end
   end

   // Next time/alarm: ticking with carries, or single-field edits without carry.
   always_comb begin
      t_sec_d = t_sec_q;
      t_min_d = t_min_q;
      t_hr_d  = t_hr_q;
      a_sec_d = a_sec_q;
      a_min_d = a_min_q;
      a_hr_d  = a_hr_q;
      if (time_upd) begin
         t_sec_d = sec_nx[7:0];
         if (sec_nx[8]) begin
            t_min_d = min_nx[7:0];
            if (min_nx[8]) t_hr_d = hr_nx[7:0];
         end
      end
      // Time edits only happen in modes where the time is frozen, so they
      // never collide with a tick update above.
      if (inc_act) begin
         case (mode_q)
            M_SET_HR:  t_hr_d  = hr_nx[7:0];
            M_SET_MIN: t_min_d = min_nx[7:0];
            M_SET_SEC: t_sec_d = sec_nx[7:0];
            M_AL_HR:   a_hr_d  = ahr_nx[7:0];
            M_AL_MIN:  a_min_d = amin_nx[7:0];
            M_AL_SEC:  a_sec_d = asec_nx[7:0];
            default:   ;
         endcase
      end
   end

   // Time and alarm registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_sec_q <= '0;
         t_min_q <= '0;
         t_hr_q  <= '0;
         a_sec_q <= '0;
         a_min_q <= '0;
         a_hr_q  <= '0;
      end else begin
         t_sec_q <= t_sec_d;
         t_min_q <= t_min_d;
         t_hr_q  <= t_hr_d;
         a_sec_q <= a_sec_d;
         a_min_q <= a_min_d;
         a_hr_q  <= a_hr_d;
      end
   end

   // Match is judged on the cycle after a ticking update, so edits that
   // land on the alarm time never ring.
   assign time_eq  = ({t_hr_q, t_min_q, t_sec_q} == {a_hr_q, a_min_q, a_sec_q});
   assign ring_tc  = ring_q & tick_1hz & (rcnt_q + 6'd1 == RING_TC);
   assign ring_clr = (inc_act & (mode_q == M_RUN)) | ~alarm_en | ring_tc;
   assign ring_set = upd_q & alarm_en & time_eq;

   // Alarm ring and its duration counter; any clear beats a new match.
   always_comb begin
      ring_d = ring_q;
      rcnt_d = rcnt_q;
      if (ring_clr) begin
         ring_d = 1'b0;
         rcnt_d = '0;
      end else if (ring_set) begin
         ring_d = 1'b1;
         rcnt_d = '0;
      end else if (ring_q && tick_1hz) begin
         rcnt_d = rcnt_q + 6'd1;
      end
   end

   // Alarm state, tick-update flag and 12/24 h toggle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ring_q   <= 1'b0;
         rcnt_q   <= '0;
         upd_q    <= 1'b0;
         twelve_q <= 1'b0;
      end else begin
         ring_q   <= ring_d;
         rcnt_q   <= rcnt_d;
         upd_q    <= time_upd;
         twelve_q <= twelve_q ^ btn_12h;
      end
   end

   assign mode       = mode_q;
   assign twelve     = twelve_q;
   assign alarm_ring = ring_q;
   assign sec0       = t_sec_q[3:0];
   assign sec1       = t_sec_q[7:4];
   assign min0       = t_min_q[3:0];
   assign min1       = t_min_q[7:4];
   assign hour0      = t_hr_q[3:0];
   assign hour1      = t_hr_q[7:4];
   assign asec0      = a_sec_q[3:0];
   assign asec1      = a_sec_q[7:4];
   assign amin0      = a_min_q[3:0];
   assign amin1      = a_min_q[7:4];
   assign ahour0     = a_hr_q[3:0];
   assign ahour1     = a_hr_q[7:4];

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed table, corner sequences and random
// stimulus against a seconds-based reference model.
module tb_clock_mode_ctrl;

   localparam int TO = 30;
   localparam int RT = 60;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_1hz = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0, btn_12h = 1'b0;
   logic       alarm_en = 1'b0;
   logic [2:0] mode;
   logic       twelve, alarm_ring;
   logic [3:0] sec0, sec1, min0, min1, hour0, hour1;
   logic [3:0] asec0, asec1, amin0, amin1, ahour0, ahour1;

   clock_mode_ctrl #(.TIMEOUT_TICKS(TO), .RING_TICKS(RT)) dut (
      .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
      .btn_inc(btn_inc), .btn_12h(btn_12h), .alarm_en(alarm_en),
      .mode(mode), .twelve(twelve),
      .sec0(sec0), .sec1(sec1), .min0(min0), .min1(min1), .hour0(hour0), .hour1(hour1),
      .asec0(asec0), .asec1(asec1), .amin0(amin0), .amin1(amin1),
      .ahour0(ahour0), .ahour1(ahour1), .alarm_ring(alarm_ring)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   bit en_lvl = 1'b0;

   // Reference model: time and alarm as seconds of the day.
   int m_mode, m_idle, m_t, m_a, m_rcnt;
   bit m_tw, m_ring, m_upd;

   typedef struct {
      bit         t, bm, bi, b12;
      logic [2:0] e_mode;
      bit         e_tw;
      logic [23:0] e_time, e_alarm;
      bit         e_ring;
   } vec_t;
   vec_t tbl[17];

   function automatic logic [23:0] to_bcd(input int v);
      int h, m, s;
      h = v / 3600; m = (v / 60) % 60; s = v % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic int edit_field(input int v, input int field);
      int h, m, s;
      h = v / 3600; m = (v / 60) % 60; s = v % 60;
      if (field == 0) h = (h + 1) % 24;
      else if (field == 1) m = (m + 1) % 60;
      else s = (s + 1) % 60;
      return h * 3600 + m * 60 + s;
   endfunction

   function automatic logic [23:0] dut_time();
      return {hour1, hour0, min1, min0, sec1, sec0};
   endfunction

   function automatic logic [23:0] dut_alarm();
      return {ahour1, ahour0, amin1, amin0, asec1, asec0};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_idle = 0; m_t = 0; m_a = 0; m_rcnt = 0;
      m_tw = 0; m_ring = 0; m_upd = 0;
   endtask

   task automatic model_step(input bit t, input bit bm, input bit bi, input bit b12, input bit en);
      int nm, ni, nt, na, nc;
      bit nr, nu, inc_eff, frozen, clr, mat;
      nm = m_mode; ni = m_idle; nt = m_t; na = m_a; nr = m_ring; nc = m_rcnt; nu = 0;
      inc_eff = bi && !bm;
      frozen = (m_mode >= 1 && m_mode <= 3);
      if (m_mode == 0) begin
         ni = 0;
         if (bm) nm = 1;
      end else if (bm || bi) begin
         ni = 0;
         if (bm) nm = (m_mode + 1) % 7;
      end else if (t && TO > 0) begin
         ni = m_idle + 1;
         if (ni == TO) begin nm = 0; ni = 0; end
      end
      if (t && !frozen) begin
         nt = (m_t + 1) % 86400;
         nu = 1;
      end else if (inc_eff && frozen) begin
         nt = edit_field(m_t, m_mode - 1);
      end
      if (inc_eff && m_mode >= 4) na = edit_field(m_a, m_mode - 4);
      clr = (inc_eff && m_mode == 0) || !en || (m_ring && t && m_rcnt + 1 == RT);
      mat = m_upd && en && (m_t == m_a);
      if (clr) begin nr = 0; nc = 0; end
      else if (mat) begin nr = 1; nc = 0; end
      else if (m_ring && t) nc = m_rcnt + 1;
      m_mode = nm; m_idle = ni; m_t = nt; m_a = na; m_ring = nr; m_rcnt = nc; m_upd = nu;
      m_tw = m_tw ^ b12;
   endtask

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
   endtask

   task automatic compare_model();
      check("mode", 24'(mode), 24'(m_mode));
      check("twelve", 24'(twelve), 24'(m_tw));
      check("time", dut_time(), to_bcd(m_t));
      check("alarm", dut_alarm(), to_bcd(m_a));
      check("ring", 24'(alarm_ring), 24'(m_ring));
   endtask

   // One clock: drive inputs, step model on the edge, compare 1 ns later.
   task automatic do_cycle(input bit t, input bit bm, input bit bi, input bit b12);
      tick_1hz = t; btn_mode = bm; btn_inc = bi; btn_12h = b12; alarm_en = en_lvl;
      @(posedge clk);
      model_step(t, bm, bi, b12, en_lvl);
      #1;
      compare_model();
      tick_1hz = 0; btn_mode = 0; btn_inc = 0; btn_12h = 0;
   endtask

   task automatic do_reset();
      tick_1hz = 0; btn_mode = 0; btn_inc = 0; btn_12h = 0;
      rst_n = 0;
      #2;
      model_reset();
      @(negedge clk);
      rst_n = 1;
   endtask

   // Walk the edit modes from run mode and set a time or alarm value.
   task automatic set_fields(input bit alarm, input int h, input int m, input int s);
      int cur, n;
      for (int i = 0; i < (alarm ? 4 : 1); i++) do_cycle(0, 1, 0, 0);
      cur = alarm ? m_a : m_t;
      n = (h - cur / 3600 + 24) % 24;
      repeat (n) do_cycle(0, 0, 1, 0);
      do_cycle(0, 1, 0, 0);
      cur = alarm ? m_a : m_t;
      n = (m - (cur / 60) % 60 + 60) % 60;
      repeat (n) do_cycle(0, 0, 1, 0);
      do_cycle(0, 1, 0, 0);
      cur = alarm ? m_a : m_t;
      n = (s - cur % 60 + 60) % 60;
      repeat (n) do_cycle(0, 0, 1, 0);
      for (int i = 0; i < 7 && m_mode != 0; i++) do_cycle(0, 1, 0, 0);
   endtask

   task automatic tick_gap(input int n);
      repeat (n) begin
         do_cycle(1, 0, 0, 0);
         do_cycle(0, 0, 0, 0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{0,0,0,1, 3'd0, 1, 24'h000000, 24'h000000, 0};
      tbl[1]  = '{1,0,0,0, 3'd0, 1, 24'h000001, 24'h000000, 0};
      tbl[2]  = '{0,1,0,0, 3'd1, 1, 24'h000001, 24'h000000, 0};
      tbl[3]  = '{0,0,1,0, 3'd1, 1, 24'h010001, 24'h000000, 0};
      tbl[4]  = '{1,0,0,0, 3'd1, 1, 24'h010001, 24'h000000, 0};
      tbl[5]  = '{0,1,1,0, 3'd2, 1, 24'h010001, 24'h000000, 0};
      tbl[6]  = '{0,0,1,0, 3'd2, 1, 24'h010101, 24'h000000, 0};
      tbl[7]  = '{0,1,0,0, 3'd3, 1, 24'h010101, 24'h000000, 0};
      tbl[8]  = '{0,0,1,0, 3'd3, 1, 24'h010102, 24'h000000, 0};
      tbl[9]  = '{0,0,0,1, 3'd3, 0, 24'h010102, 24'h000000, 0};
      tbl[10] = '{0,1,0,0, 3'd4, 0, 24'h010102, 24'h000000, 0};
      tbl[11] = '{1,0,1,0, 3'd4, 0, 24'h010103, 24'h010000, 0};
      tbl[12] = '{0,1,0,0, 3'd5, 0, 24'h010103, 24'h010000, 0};
      tbl[13] = '{0,0,1,0, 3'd5, 0, 24'h010103, 24'h010100, 0};
      tbl[14] = '{0,1,0,0, 3'd6, 0, 24'h010103, 24'h010100, 0};
      tbl[15] = '{0,1,0,0, 3'd0, 0, 24'h010103, 24'h010100, 0};
      tbl[16] = '{1,0,0,0, 3'd0, 0, 24'h010104, 24'h010100, 0};

      // Reset state
      model_reset();
      #12;
      check("rst_mode", 24'(mode), 24'd0);
      check("rst_time", dut_time(), 24'h0);
      check("rst_alarm", dut_alarm(), 24'h0);
      check("rst_ring", 24'(alarm_ring), 24'd0);
      check("rst_twelve", 24'(twelve), 24'd0);
      @(negedge clk);
      rst_n = 1;

      // Directed table
      en_lvl = 0;
      for (int i = 0; i < 17; i++) begin
         do_cycle(tbl[i].t, tbl[i].bm, tbl[i].bi, tbl[i].b12);
         check($sformatf("tbl%0d_mode", i), 24'(mode), 24'(tbl[i].e_mode));
         check($sformatf("tbl%0d_twelve", i), 24'(twelve), 24'(tbl[i].e_tw));
         check($sformatf("tbl%0d_time", i), dut_time(), tbl[i].e_time);
         check($sformatf("tbl%0d_alarm", i), dut_alarm(), tbl[i].e_alarm);
         check($sformatf("tbl%0d_ring", i), 24'(alarm_ring), 24'(tbl[i].e_ring));
      end

      // Hour edit wraps at 24; ticks ignored in mode 1
      do_reset();
      do_cycle(0, 1, 0, 0);
      repeat (25) do_cycle(0, 0, 1, 0);
      check("hr25_mode", 24'(mode), 24'd1);
      check("hr25_time", dut_time(), 24'h010000);
      do_cycle(1, 0, 0, 0);
      check("frozen_time", dut_time(), 24'h010000);

      // Carry chains set up by editing
      do_reset();
      set_fields(0, 23, 59, 58);
      do_cycle(1, 0, 0, 0);
      check("wrap_a", dut_time(), 24'h235959);
      do_cycle(1, 0, 0, 0);
      check("wrap_b", dut_time(), 24'h000000);
      set_fields(0, 9, 59, 59);
      do_cycle(1, 0, 0, 0);
      check("h09_10", dut_time(), 24'h100000);
      set_fields(0, 19, 59, 59);
      do_cycle(1, 0, 0, 0);
      check("h19_20", dut_time(), 24'h200000);

      // Continuous run from midnight
      do_reset();
      for (int i = 1; i <= 3600; i++) begin
         do_cycle(1, 0, 0, 0);
         if (i == 59)   check("run_59", dut_time(), 24'h000059);
         if (i == 60)   check("run_100", dut_time(), 24'h000100);
         if (i == 3600) check("run_1h", dut_time(), 24'h010000);
      end

      // Alarm rings one cycle after the matching tick, expires after RT ticks
      do_reset();
      en_lvl = 0;
      set_fields(1, 0, 0, 5);
      check("alarm_set", dut_alarm(), 24'h000005);
      en_lvl = 1;
      tick_gap(4);
      do_cycle(1, 0, 0, 0);
      check("ring_tick5", 24'(alarm_ring), 24'd0);
      do_cycle(0, 0, 0, 0);
      check("ring_after5", 24'(alarm_ring), 24'd1);
      tick_gap(59);
      check("ring_59", 24'(alarm_ring), 24'd1);
      do_cycle(1, 0, 0, 0);
      check("ring_60", 24'(alarm_ring), 24'd0);

      // Acknowledge with btn_inc in run mode
      do_reset();
      en_lvl = 0;
      set_fields(1, 0, 0, 5);
      en_lvl = 1;
      tick_gap(5);
      check("ack_ring", 24'(alarm_ring), 24'd1);
      tick_gap(3);
      check("ack_before", 24'(alarm_ring), 24'd1);
      do_cycle(0, 0, 1, 0);
      check("ack_after", 24'(alarm_ring), 24'd0);
      check("ack_time", dut_time(), 24'h000008);

      // Idle timeout in mode 2
      do_reset();
      en_lvl = 0;
      do_cycle(0, 1, 0, 0);
      do_cycle(0, 1, 0, 0);
      repeat (29) do_cycle(1, 0, 0, 0);
      check("to_29", 24'(mode), 24'd2);
      do_cycle(1, 0, 0, 0);
      check("to_30", 24'(mode), 24'd0);
      do_cycle(0, 1, 0, 0);
      do_cycle(0, 1, 0, 0);
      repeat (28) do_cycle(1, 0, 0, 0);
      do_cycle(1, 0, 1, 0);
      check("to_btn29", 24'(mode), 24'd2);
      do_cycle(1, 0, 0, 0);
      check("to_btn30", 24'(mode), 24'd2);
      repeat (28) do_cycle(1, 0, 0, 0);
      check("to_re29", 24'(mode), 24'd2);
      do_cycle(1, 0, 0, 0);
      check("to_re30", 24'(mode), 24'd0);

      // Asynchronous reset while ringing in mode 5
      do_reset();
      en_lvl = 0;
      set_fields(1, 0, 0, 3);
      en_lvl = 1;
      do_cycle(0, 0, 0, 1);
      tick_gap(3);
      repeat (5) do_cycle(0, 1, 0, 0);
      check("pre_rst_mode", 24'(mode), 24'd5);
      check("pre_rst_ring", 24'(alarm_ring), 24'd1);
      #2;
      rst_n = 0;
      #1;
      check("arst_mode", 24'(mode), 24'd0);
      check("arst_twelve", 24'(twelve), 24'd0);
      check("arst_time", dut_time(), 24'h0);
      check("arst_alarm", dut_alarm(), 24'h0);
      check("arst_ring", 24'(alarm_ring), 24'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      do_cycle(1, 0, 0, 0);
      check("post_rst_tick", dut_time(), 24'h000001);

      // Random stimulus against the model
      do_reset();
      en_lvl = 0;
      set_fields(1, 0, 0, 20);
      en_lvl = 1;
      for (int i = 0; i < 20000; i++) begin
         if ($urandom_range(0, 299) == 0) en_lvl = ~en_lvl;
         do_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
